transmitter_fifo: RTL

TRANSMITTER_FIFO -- requirements
Module: transmitter_fifo

---
 rtl/transmitter_fifo.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/transmitter_fifo.sv
// Byte-wide FIFO feeding an 8N1 serial transmitter; one bounderClock edge per bit time.
// Frames run back-to-back while bytes are queued; DONE pulses for the cycle after each stop bit.
module transmitter_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       bounderClock,
  input  logic       reset,
  input  logic [7:0] datain,
  input  logic       IN_WRITE,
  output logic       txbit,
  output logic       OUT_STATUS_FULL,
  output logic       OUT_STATUS_BUSY,
  output logic       OUT_STATUS_DONE,
  output logic [1:0] o_dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [7:0]         r_shift;
  logic [2:0]         r_idx;
  logic               r_txbit;
  logic               r_done;

  logic               w_full;
  logic               w_wr_acc;
  logic               w_pop;
  logic [7:0]         w_shift_nxt;
  logic [2:0]         w_idx_nxt;
  logic               w_tx_nxt;
  logic               w_done_nxt;

  // Full is taken from the registered count, so a write offered while full is
  // dropped even when the transmitter frees a slot on that same edge.
  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_wr_acc = IN_WRITE && !w_full;

  // FSM next-state and datapath next values.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_tx_nxt    = r_txbit;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt    = r_shift[0];
        w_idx_nxt   = 3'd0;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (r_idx == 3'd7) begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_shift_nxt = r_shift >> 1;
          w_tx_nxt    = r_shift[1];
          w_idx_nxt   = r_idx + 3'd1;
        end
      end
      S_STOP: begin
        w_done_nxt = 1'b1;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end else begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge bounderClock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_txbit <= 1'b1;
      r_idx   <= 3'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_txbit <= w_tx_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Storage and shift register hold no reset value.
  always_ff @(posedge bounderClock) begin
    r_shift <= w_shift_nxt;
    if (w_wr_acc && !reset) begin
      r_mem[r_wr_ptr] <= datain;
    end
  end

  always_ff @(posedge bounderClock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign txbit           = r_txbit;
  assign OUT_STATUS_FULL = w_full;
  assign OUT_STATUS_BUSY = (r_state != S_IDLE) || (r_count != '0);
  assign OUT_STATUS_DONE = r_done;
  assign o_dbg_state     = r_state;

endmodule
